// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
//   Shared definitions for the sum_sequencer lab design and its button
//   front end: FSM state encoding, default operand width and debounce
//   length, and a small helper for sizing the debounce counter.
// -----------------------------------------------------------------------------
package sum_pkg;

    // Default operand width in bits.
    localparam int DEF_WIDTH     = 8;

    // Default number of cycles a synchronized level must hold before acceptance.
    localparam int DEF_DB_CYCLES = 4;

    // Sequencer states. The encoding is visible on state_o, so it is fixed.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_ADD  = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Width of a counter that must hold values 0 .. n-1 (at least one bit).
    function automatic int db_cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : sum_pkg

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Front end for an active-low push button that is asynchronous to clk:
//   2-flop synchronizer, counting debouncer and falling-edge detector.
//
//   Ports
//     clk       in   system clock
//     reset     in   asynchronous active-low reset
//     w_button  in   raw button, 0 = pressed
//     press     out  one-cycle pulse on each debounced press (1->0 transition)
//
//   After reset the block is "disarmed": it must first see the button
//   released (synchronized level high) for DB_CYCLES consecutive cycles
//   before any press can be reported. This keeps a button that is held
//   through reset deassertion from producing a spurious press.
// -----------------------------------------------------------------------------
module button_debounce
    import sum_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic w_button,
    output logic press
);

    localparam int CW = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;   // debounced level, 1 = released
    logic          armed_reg;   // a clean release has been seen since reset
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    // Condition the counter is timing this cycle. While disarmed we time a
    // stable release; once armed we time a difference from the debounced level.
    logic target;

    always_comb begin
        target = 1'b0;
        if (armed_reg) begin
            target = (sync2_reg != level_reg);
        end else begin
            target = sync2_reg;
        end
    end

    // The synchronizer clears to 0 ("pressed" in raw terms) so that its reset
    // contents can never count toward the release needed to arm the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b1;
            armed_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= w_button;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;

            if (!target) begin
                // Any glitch back to the current level restarts the timing.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                if (armed_reg) begin
                    level_reg <= sync2_reg;
                    // Only the debounced fall is an event; release is silent.
                    press_reg <= ~sync2_reg;
                end else begin
                    armed_reg <= 1'b1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule : button_debounce

// File: rtl/sum_sequencer.sv
// -----------------------------------------------------------------------------
// sum_sequencer
//   Button-driven two-operand adder. Successive presses load operand A,
//   load operand B, and then the sum is computed and shown. From the show
//   state a press either chains (sum becomes the new A) or restarts with a
//   fresh A from the switches.
//
//   Ports
//     clk       in   system clock
//     reset     in   asynchronous active-low reset
//     w_button  in   raw push button, active-low, asynchronous to clk
//     acc_mode  in   1 = chain the previous sum into A on the next press
//     switch1   in   [WIDTH]   operand source
//     op_a      out  [WIDTH]   registered operand A
//     op_b      out  [WIDTH]   registered operand B
//     sum       out  [WIDTH+1] registered A+B, MSB = carry
//     diod      out  carry LED, equals sum[WIDTH]
//     ovf       out  sticky carry over the current accumulate chain
//     state_o   out  [2]       current state encoding
// -----------------------------------------------------------------------------
module sum_sequencer
    import sum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_button,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] switch1,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH:0]   sum,
    output logic             diod,
    output logic             ovf,
    output logic [1:0]       state_o
);

    logic press;

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_button (
        .clk      (clk),
        .reset    (reset),
        .w_button (w_button),
        .press    (press)
    );

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] op_a_reg,  op_a_next;
    logic [WIDTH-1:0] op_b_reg,  op_b_next;
    logic [WIDTH:0]   sum_reg,   sum_next;
    logic             ovf_reg,   ovf_next;

    // The one adder in the design; its carry lands in the MSB.
    logic [WIDTH:0] add_result;
    assign add_result = {1'b0, op_a_reg} + {1'b0, op_b_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_A;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            sum_reg   <= sum_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        sum_next   = sum_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            S_A: begin
                if (press) begin
                    op_a_next  = switch1;
                    ovf_next   = 1'b0;
                    state_next = S_B;
                end
            end

            S_B: begin
                if (press) begin
                    op_b_next  = switch1;
                    state_next = S_ADD;
                end
            end

            // One-cycle compute state; a press landing here is ignored.
            S_ADD: begin
                sum_next   = add_result;
                ovf_next   = ovf_reg | add_result[WIDTH];
                state_next = S_SHOW;
            end

            S_SHOW: begin
                if (press) begin
                    if (acc_mode) begin
                        // Chain: keep B and the sticky carry, sum becomes A.
                        op_a_next = sum_reg[WIDTH-1:0];
                    end else begin
                        // Restart: sum is left on display until the next add.
                        op_a_next = switch1;
                        op_b_next = '0;
                        ovf_next  = 1'b0;
                    end
                    state_next = S_B;
                end
            end

            default: begin
                state_next = S_A;
            end
        endcase
    end

    assign op_a    = op_a_reg;
    assign op_b    = op_b_reg;
    assign sum     = sum_reg;
    assign diod    = sum_reg[WIDTH];
    assign ovf     = ovf_reg;
    assign state_o = state_reg;

endmodule : sum_sequencer
